// File: rtl/midori_sbox_layer_ctrl.sv
// Serial sequencer for an external 3-share masked Midori S-box: one nibble per share per cycle in, ordered collection out.
// Optional macro SBOX_ZERO_FLUSH_EN adds a zero-input FLUSH phase after DRAIN so no share data lingers in the S-box.
module midori_sbox_layer_ctrl #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_in_s0,
  input  logic [4*NIBBLES-1:0] state_in_s1,
  input  logic [4*NIBBLES-1:0] state_in_s2,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] state_out_s0,
  output logic [4*NIBBLES-1:0] state_out_s1,
  output logic [4*NIBBLES-1:0] state_out_s2,
  output logic                 sbox_en,
  output logic [3:0]           sbox_in_s0,
  output logic [3:0]           sbox_in_s1,
  output logic [3:0]           sbox_in_s2,
  input  logic [3:0]           sbox_out_s0,
  input  logic [3:0]           sbox_out_s1,
  input  logic [3:0]           sbox_out_s2
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam int LW = $clog2(SBOX_LAT + 1);

`ifdef SBOX_ZERO_FLUSH_EN
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, FLUSH, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, DONE} state_t;
`endif

  state_t              state_reg;
  logic [CW-1:0]       feed_cnt_reg;
  logic [CW-1:0]       collect_cnt_reg;
  logic [LW-1:0]       lat_cnt_reg;
  logic [SBOX_LAT-1:0] valid_sr_reg;
  logic [SBOX_LAT:0]   valid_sr_next;
  logic                feeding;
  logic                load;
  logic                feed_step;
  logic                capture;

  assign feeding       = (state_reg == FEED);
  assign load          = (state_reg == IDLE) && start;
  assign feed_step     = feeding && (feed_cnt_reg != CW'(NIBBLES));
  // The valid bit of a nibble reaches the top tap exactly when its S-box result appears.
  assign valid_sr_next = {valid_sr_reg, feeding};
  assign capture       = valid_sr_reg[SBOX_LAT-1] && (collect_cnt_reg != CW'(NIBBLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      feed_cnt_reg    <= '0;
      collect_cnt_reg <= '0;
      lat_cnt_reg     <= '0;
      valid_sr_reg    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sbox_en         <= 1'b0;
    end else begin
      valid_sr_reg <= valid_sr_next[SBOX_LAT-1:0];
      done         <= 1'b0;
      if (capture) begin
        collect_cnt_reg <= collect_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= FEED;
            feed_cnt_reg    <= CW'(1);
            collect_cnt_reg <= '0;
            busy            <= 1'b1;
            sbox_en         <= 1'b1;
          end
        end
        FEED: begin
          if (feed_cnt_reg == CW'(NIBBLES)) begin
            state_reg   <= DRAIN;
            lat_cnt_reg <= LW'(1);
          end else begin
            feed_cnt_reg <= feed_cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (lat_cnt_reg == LW'(SBOX_LAT)) begin
`ifdef SBOX_ZERO_FLUSH_EN
            state_reg   <= FLUSH;
            lat_cnt_reg <= LW'(1);
`else
            state_reg   <= DONE;
            busy        <= 1'b0;
            sbox_en     <= 1'b0;
            done        <= 1'b1;
`endif
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
`ifdef SBOX_ZERO_FLUSH_EN
        FLUSH: begin
          if (lat_cnt_reg == LW'(SBOX_LAT)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            sbox_en   <= 1'b0;
            done      <= 1'b1;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
`endif
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each share has its own independent datapath; shares never meet inside this block.
  for (genvar gi = 0; gi < 3; gi++) begin : g_share
    logic [W-1:0] in_share;
    logic [W-1:0] shift_reg;
    logic [W-1:0] out_reg;
    logic [W-1:0] out_next;
    logic [3:0]   nib_reg;
    logic [3:0]   sbox_nib;

    if (gi == 0) begin : g_s0
      assign in_share     = state_in_s0;
      assign sbox_nib     = sbox_out_s0;
      assign state_out_s0 = out_reg;
      assign sbox_in_s0   = nib_reg;
    end else if (gi == 1) begin : g_s1
      assign in_share     = state_in_s1;
      assign sbox_nib     = sbox_out_s1;
      assign state_out_s1 = out_reg;
      assign sbox_in_s1   = nib_reg;
    end else begin : g_s2
      assign in_share     = state_in_s2;
      assign sbox_nib     = sbox_out_s2;
      assign state_out_s2 = out_reg;
      assign sbox_in_s2   = nib_reg;
    end

    always_comb begin
      out_next = out_reg;
      for (int n = 0; n < NIBBLES; n++) begin
        if (capture && (collect_cnt_reg == CW'(n))) begin
          out_next[4*n +: 4] = sbox_nib;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        shift_reg <= '0;
        nib_reg   <= '0;
        out_reg   <= '0;
      end else begin
        out_reg <= out_next;
        if (load) begin
          nib_reg   <= in_share[3:0];
          shift_reg <= in_share >> 4;
        end else if (feed_step) begin
          nib_reg   <= shift_reg[3:0];
          shift_reg <= shift_reg >> 4;
        end else begin
          nib_reg <= '0;
        end
      end
    end
  end

endmodule
